cvxif_vec_coproc: RTL and testbench

- CV-X-IF responder (coprocessor side) for the custom vector store enabled by the core config (EnableCustomVec, CustomVecNumWords).
- Accepts offloaded custom-0 instructions from the core's CVXIF initiator and executes them non-speculatively after commit.
- Owns a NumWords x XLEN word memory and returns register writebacks over the result channel.
- Sits beside the core, wired to its cvxif request/response ports.

---
 rtl/cvxif_vec_pkg.sv | 29 ++
 rtl/cvxif_vec_mem.sv | 27 ++
 rtl/cvxif_vec_coproc.sv | 211 +++++++++++++++++++++
 tb/tb_cvxif_vec_coproc.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_vec_pkg.sv
// Shared types and constants for the CV-X-IF custom vector coprocessor.
package cvxif_vec_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_VWR  = 3'b000;
  localparam logic [2:0] F3_VRD  = 3'b001;
  localparam logic [2:0] F3_VSUM = 3'b010;

  typedef enum logic [1:0] {
    OpVwr,
    OpVrd,
    OpVsum
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitCommit,
    StExec,
    StResp
  } state_e;

  // Width-independent part of the latched instruction; id/idx/operands are parameter-sized.
  typedef struct packed {
    op_e        op;
    logic [4:0] rd;
  } instr_meta_t;

endpackage

// File: rtl/cvxif_vec_mem.sv
// Single-port synchronous RAM, 1-cycle read latency, no reset. Read data holds between reads.
module cvxif_vec_mem #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 512,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/cvxif_vec_coproc.sv
// CV-X-IF responder executing custom-0 vector store ops (VWR/VRD/VSUM) after commit.
// Define CVXIF_VEC_SAT_EN for unsigned saturating VSUM accumulation.
module cvxif_vec_coproc
  import cvxif_vec_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NumWords = 512,
  parameter int unsigned IdWidth  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [IdWidth-1:0]  issue_id_i,
  input  logic [2*XLEN-1:0]   issue_rs_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [IdWidth-1:0]  commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [IdWidth-1:0]  result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic [XLEN-1:0]     result_data_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned CntW = IdxW + 1;

  state_e             state_q, state_d;
  instr_meta_t        meta_q, meta_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]    rs2_q, rs2_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CntW-1:0]    nrd_q, nrd_d;
  logic               pend_q, pend_d;
  logic [XLEN-1:0]    acc_q, acc_d;

  logic [XLEN-1:0] rs1, rs2;
  logic [CntW-1:0] cnt_new;
  logic            dec_ok, accept, commit_hit_issue, commit_hit_wait;
  op_e             dec_op;

  logic            mem_en, mem_we;
  logic [IdxW-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;

  logic unused_rs1;

  assign rs1 = issue_rs_i[XLEN-1:0];
  assign rs2 = issue_rs_i[2*XLEN-1:XLEN];
  assign unused_rs1 = ^rs1[XLEN-1:IdxW];

  assign cnt_new = (rs2 >= XLEN'(NumWords)) ? CntW'(NumWords) : rs2[CntW-1:0];

  always_comb begin
    dec_ok = 1'b0;
    dec_op = OpVwr;
    if (issue_instr_i[6:0] == OPC_CUSTOM0) begin
      unique case (issue_instr_i[14:12])
        F3_VWR:  begin dec_ok = 1'b1; dec_op = OpVwr;  end
        F3_VRD:  begin dec_ok = 1'b1; dec_op = OpVrd;  end
        F3_VSUM: begin dec_ok = 1'b1; dec_op = OpVsum; end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  assign accept           = (state_q == StIdle) && issue_valid_i && dec_ok;
  assign commit_hit_issue = commit_valid_i && (commit_id_i == issue_id_i);
  assign commit_hit_wait  = commit_valid_i && (commit_id_i == id_q);

  function automatic logic [XLEN-1:0] acc_add(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef CVXIF_VEC_SAT_EN
    logic [XLEN:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[XLEN] ? {XLEN{1'b1}} : s[XLEN-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    meta_d  = meta_q;
    id_d    = id_q;
    idx_d   = idx_q;
    rs2_d   = rs2_q;
    cnt_d   = cnt_q;
    nrd_d   = nrd_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          meta_d = '{op: dec_op, rd: issue_instr_i[11:7]};
          id_d   = issue_id_i;
          idx_d  = rs1[IdxW-1:0];
          rs2_d  = rs2;
          cnt_d  = cnt_new;
          nrd_d  = '0;
          pend_d = 1'b0;
          acc_d  = '0;
          // A matching commit in the handshake cycle skips WAIT_COMMIT.
          if (commit_hit_issue) begin
            state_d = commit_kill_i ? StIdle : StExec;
          end else begin
            state_d = StWaitCommit;
          end
        end
      end
      StWaitCommit: begin
        if (commit_hit_wait) begin
          state_d = commit_kill_i ? StIdle : StExec;
        end
      end
      StExec: begin
        unique case (meta_q.op)
          OpVwr: begin
            mem_en  = 1'b1;
            mem_we  = 1'b1;
            state_d = StIdle;
          end
          OpVrd: begin
            mem_en  = 1'b1;
            state_d = StResp;
          end
          OpVsum: begin
            if (pend_q) begin
              acc_d = acc_add(acc_q, mem_rdata);
            end
            // Reads are pipelined one ahead of accumulation; leave once the last read has landed.
            if (nrd_q < cnt_q) begin
              mem_en = 1'b1;
              nrd_d  = nrd_q + 1'b1;
              pend_d = 1'b1;
            end else begin
              pend_d  = 1'b0;
              state_d = StResp;
            end
          end
          default: state_d = StIdle;
        endcase
      end
      StResp: begin
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      meta_q  <= '{op: OpVwr, rd: 5'd0};
      id_q    <= '0;
      idx_q   <= '0;
      rs2_q   <= '0;
      cnt_q   <= '0;
      nrd_q   <= '0;
      pend_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      rs2_q   <= rs2_d;
      cnt_q   <= cnt_d;
      nrd_q   <= nrd_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
    end
  end

  assign mem_addr = idx_q + nrd_q[IdxW-1:0];

  cvxif_vec_mem #(
    .Width(XLEN),
    .Depth(NumWords)
  ) u_mem (
    .clk  (clk_i),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(rs2_q),
    .rdata(mem_rdata)
  );

  assign issue_ready_o     = (state_q == StIdle);
  assign issue_accept_o    = accept;
  assign issue_writeback_o = accept && (dec_op != OpVwr);

  // VRD returns the RAM output directly; it is stable because no read is issued in RESP.
  assign result_valid_o = (state_q == StResp);
  assign result_id_o    = result_valid_o ? id_q : '0;
  assign result_rd_o    = result_valid_o ? meta_q.rd : 5'd0;
  assign result_we_o    = result_valid_o;
  assign result_data_o  = !result_valid_o       ? '0 :
                          (meta_q.op == OpVrd)  ? mem_rdata : acc_q;

endmodule

// File: tb/tb_cvxif_vec_coproc.sv
// Directed self-checking bench for cvxif_vec_coproc (honours CVXIF_VEC_SAT_EN when defined).
module tb_cvxif_vec_coproc;
  import cvxif_vec_pkg::*;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NumWords = 512;
  localparam int unsigned IdWidth  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                issue_valid = 1'b0;
  logic                issue_ready;
  logic [31:0]         issue_instr = '0;
  logic [IdWidth-1:0]  issue_id = '0;
  logic [2*XLEN-1:0]   issue_rs = '0;
  logic                issue_accept;
  logic                issue_writeback;
  logic                commit_valid = 1'b0;
  logic [IdWidth-1:0]  commit_id = '0;
  logic                commit_kill = 1'b0;
  logic                result_valid;
  logic                result_ready = 1'b0;
  logic [IdWidth-1:0]  result_id;
  logic [4:0]          result_rd;
  logic                result_we;
  logic [XLEN-1:0]     result_data;

  int checks = 0;
  int failures = 0;
  logic [IdWidth-1:0] nid = 4'd1;

  always #5 clk = ~clk;

  cvxif_vec_coproc #(
    .XLEN(XLEN),
    .NumWords(NumWords),
    .IdWidth(IdWidth)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_instr_i    (issue_instr),
    .issue_id_i       (issue_id),
    .issue_rs_i       (issue_rs),
    .issue_accept_o   (issue_accept),
    .issue_writeback_o(issue_writeback),
    .commit_valid_i   (commit_valid),
    .commit_id_i      (commit_id),
    .commit_kill_i    (commit_kill),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready),
    .result_id_o      (result_id),
    .result_rd_o      (result_rd),
    .result_we_o      (result_we),
    .result_data_o    (result_data)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, OPC_CUSTOM0};
  endfunction

  // All stimulus tasks start and end at a posedge+1 slot.
  task automatic do_issue(input logic [31:0] instr, input logic [IdWidth-1:0] id,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic with_commit,
                          output logic rdy, output logic acc, output logic wb);
    issue_valid  = 1'b1;
    issue_instr  = instr;
    issue_id     = id;
    issue_rs     = {rs2, rs1};
    commit_valid = with_commit;
    commit_id    = id;
    commit_kill  = 1'b0;
    #1;
    rdy = issue_ready;
    acc = issue_accept;
    wb  = issue_writeback;
    @(posedge clk);
    #1;
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [IdWidth-1:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  // Called in the slot after the commit cycle; lat counts cycles from commit to valid.
  task automatic wait_result(input int budget, output int lat);
    lat = 1;
    while (!result_valid && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic write_word(input logic [63:0] idx, input logic [63:0] val);
    logic r, a, w;
    do_issue(mk(F3_VWR, 5'd0), nid, idx, val, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    nid++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || result_valid !== 1'b0 || issue_accept !== 1'b0 ||
        issue_writeback !== 1'b0 || result_data !== '0 || result_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b acc=%b wb=%b data=%h we=%b",
               issue_ready, result_valid, issue_accept, issue_writeback, result_data, result_we);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    logic r, a, w;
    int lat;
    do_issue(mk(F3_VWR, 5'd0), nid, 64'd5, 64'hDEAD_BEEF, 1'b0, r, a, w);
    checks++;
    if (r !== 1'b1 || a !== 1'b1 || w !== 1'b0) begin
      failures++;
      $display("FAIL vwr_issue: ready=%b acc=%b wb=%b need 1 1 0", r, a, w);
    end
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL wait_commit_ready: got %b need 0", issue_ready);
    end
    do_commit(nid, 1'b0);
    nid++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL vwr_no_result: valid=%b ready=%b need 0 1", result_valid, issue_ready);
    end
    do_issue(mk(F3_VRD, 5'd10), nid, 64'd5, 64'd0, 1'b0, r, a, w);
    checks++;
    if (a !== 1'b1 || w !== 1'b1) begin
      failures++;
      $display("FAIL vrd_issue: acc=%b wb=%b need 1 1", a, w);
    end
    do_commit(nid, 1'b0);
    wait_result(20, lat);
    checks++;
    if (lat !== 2 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL vrd_latency: lat=%0d valid=%b need 2 1", lat, result_valid);
    end
    checks++;
    if (result_data !== 64'hDEAD_BEEF || result_rd !== 5'd10 || result_id !== nid ||
        result_we !== 1'b1) begin
      failures++;
      $display("FAIL vrd_result: data=%h rd=%0d id=%0d we=%b need deadbeef 10 %0d 1",
               result_data, result_rd, result_id, result_we, nid);
    end
    nid++;
    take_result();
  endtask

  task automatic test_vsum_wrap();
    logic r, a, w;
    int lat;
    write_word(64'd510, 64'd1);
    write_word(64'd511, 64'd2);
    write_word(64'd0, 64'd3);
    do_issue(mk(F3_VSUM, 5'd3), nid, 64'd510, 64'd3, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    wait_result(40, lat);
    checks++;
    if (lat !== 5 || result_data !== 64'd6 || result_rd !== 5'd3) begin
      failures++;
      $display("FAIL vsum_wrap: lat=%0d data=%0d rd=%0d need 5 6 3", lat, result_data, result_rd);
    end
    nid++;
    take_result();
  endtask

  task automatic test_kill();
    logic r, a, w;
    int lat;
    int seen;
    write_word(64'd7, 64'd1);
    do_issue(mk(F3_VWR, 5'd0), nid, 64'd7, 64'd9, 1'b0, r, a, w);
    do_commit(nid, 1'b1);
    nid++;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (result_valid) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL kill_no_result: valid_cycles=%0d ready=%b need 0 1", seen, issue_ready);
    end
    do_issue(mk(F3_VRD, 5'd4), nid, 64'd7, 64'd0, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    wait_result(20, lat);
    checks++;
    if (lat !== 2 || result_data !== 64'd1) begin
      failures++;
      $display("FAIL kill_readback: lat=%0d data=%0d need 2 1", lat, result_data);
    end
    nid++;
    take_result();
  endtask

  task automatic test_reject();
    logic r, a, w;
    int seen;
    do_issue(32'h0000_0013, nid, 64'd1, 64'd2, 1'b0, r, a, w);
    checks++;
    if (r !== 1'b1 || a !== 1'b0 || w !== 1'b0) begin
      failures++;
      $display("FAIL reject_issue: ready=%b acc=%b wb=%b need 1 0 0", r, a, w);
    end
    do_issue(mk(3'b111, 5'd1), nid, 64'd1, 64'd2, 1'b0, r, a, w);
    checks++;
    if (a !== 1'b0 || w !== 1'b0) begin
      failures++;
      $display("FAIL reject_funct3: acc=%b wb=%b need 0 0", a, w);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (result_valid || !issue_ready) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reject_stays_idle: bad_cycles=%0d need 0", seen);
    end
  endtask

  task automatic test_commit_order();
    logic r, a, w;
    int lat;
    int seen;
    do_issue(mk(F3_VRD, 5'd12), nid, 64'd5, 64'd0, 1'b1, r, a, w);
    wait_result(20, lat);
    checks++;
    if (lat !== 2 || result_data !== 64'hDEAD_BEEF || result_id !== nid) begin
      failures++;
      $display("FAIL same_cycle_commit: lat=%0d data=%h id=%0d need 2 deadbeef %0d",
               lat, result_data, result_id, nid);
    end
    nid++;
    take_result();
    do_issue(mk(F3_VRD, 5'd13), nid, 64'd7, 64'd0, 1'b0, r, a, w);
    do_commit(nid + 4'd1, 1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (result_valid || issue_ready) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL nonmatch_commit_ignored: bad_cycles=%0d need 0", seen);
    end
    do_commit(nid, 1'b0);
    wait_result(20, lat);
    checks++;
    if (lat !== 2 || result_data !== 64'd1 || result_rd !== 5'd13) begin
      failures++;
      $display("FAIL late_commit: lat=%0d data=%0d rd=%0d need 2 1 13", lat, result_data, result_rd);
    end
    nid++;
    take_result();
  endtask

  task automatic test_vsum_sat();
    logic r, a, w;
    int lat;
    logic [63:0] exp;
`ifdef CVXIF_VEC_SAT_EN
    exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp = 64'hFFFF_FFFF_FFFF_FFFE;
`endif
    write_word(64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    write_word(64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_issue(mk(F3_VSUM, 5'd6), nid, 64'd0, 64'd2, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    wait_result(20, lat);
    checks++;
    if (lat !== 4 || result_data !== exp) begin
      failures++;
      $display("FAIL vsum_overflow: lat=%0d data=%h need 4 %h", lat, result_data, exp);
    end
    nid++;
    take_result();
    do_issue(mk(F3_VSUM, 5'd7), nid, 64'd3, 64'd0, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    wait_result(20, lat);
    checks++;
    if (lat !== 2 || result_data !== 64'd0 || result_rd !== 5'd7) begin
      failures++;
      $display("FAIL vsum_cnt0: lat=%0d data=%h rd=%0d need 2 0 7", lat, result_data, result_rd);
    end
    nid++;
    take_result();
  endtask

  task automatic test_stall_and_reset();
    logic r, a, w;
    int lat;
    do_issue(mk(F3_VRD, 5'd9), nid, 64'd5, 64'd0, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    wait_result(20, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL stall_latency: lat=%0d need 2", lat);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (result_valid !== 1'b1 || result_data !== 64'hDEAD_BEEF || result_rd !== 5'd9 ||
          issue_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h rd=%0d ready=%b need 1 deadbeef 9 0",
                 i, result_valid, result_data, result_rd, issue_ready);
      end
      @(posedge clk);
      #1;
    end
    nid++;
    take_result();
    do_issue(mk(F3_VSUM, 5'd8), nid, 64'd0, 64'd100, 1'b0, r, a, w);
    do_commit(nid, 1'b0);
    nid++;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: valid=%b ready=%b need 0 1", result_valid, issue_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 110; i++) begin
      if (result_valid || !issue_ready) lat++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat !== 0) begin
      failures++;
      $display("FAIL abandoned_after_reset: bad_cycles=%0d need 0", lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_vsum_wrap();
    test_kill();
    test_reject();
    test_commit_order();
    test_vsum_sat();
    test_stall_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
